// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 5208;
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through receive FIFO; a pop frees the slot a same-cycle
// push needs, so a full FIFO can accept while draining.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = DATA_BITS,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr == rptr);
  assign full = (wptr[AW] != rptr[AW]) &&
                (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronizer, mid-bit sampling FSM and FWFT FIFO
// with single-cycle framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 KEY,
  input  logic                 UART_RXD,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID_END = CW'(HALF - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rxd_m;
  logic                 rxd_s;
  rx_state_t            state_q;
  rx_state_t            state_d;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic [2:0]           bit_q;
  logic [2:0]           bit_d;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] shreg_d;
  logic                 push_q;
  logic                 push_d;
  logic                 ferr_q;
  logic                 ferr_d;
  logic                 full;
  logic                 empty;

  always_ff @(posedge CLOCK_50) begin
    if (KEY) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= UART_RXD;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (KEY) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      push_q  <= push_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = START;
      end
      START: begin
        if (cnt_q == MID_END) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          shreg_d = {rxd_s, shreg_q[DATA_BITS-1:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          state_d = rxd_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stop-bit verdict is registered so push and frame_err line up.
  always_comb begin
    busy   = (state_q != IDLE);
    push_d = 1'b0;
    ferr_d = 1'b0;
    if (state_q == STOP && cnt_q == BIT_END) begin
      push_d = rxd_s;
      ferr_d = !rxd_s;
    end
  end

  uart_rx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (CLOCK_50),
    .rst  (KEY),
    .push (push_q),
    .din  (shreg_q),
    .full (full),
    .pop  (rx_ready),
    .dout (rx_data),
    .empty(empty)
  );

  assign rx_valid  = !empty;
  assign frame_err = ferr_q;
  assign overrun   = push_q && full && !rx_ready;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: fast instance for frame scenarios,
// slow instance for one frame at the real baud divisor.
module tb_uart_rx;

  localparam int FAST = 16;
  localparam int SLOW = 5208;
  localparam int HALF = FAST / 2;

  logic       clk = 1'b0;
  logic       key = 1'b1;
  logic       rxd_a = 1'b1;
  logic       rxd_b = 1'b1;
  logic       ready_a = 1'b0;
  logic       ready_b = 1'b0;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic       valid_a;
  logic       valid_b;
  logic       fe_a;
  logic       fe_b;
  logic       ov_a;
  logic       ov_b;
  logic       busy_a;
  logic       busy_b;

  int n_chk = 0;
  int n_pass = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int bad_b = 0;
  logic [7:0] got_a [$];
  logic [7:0] got_b [$];

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(FAST), .FIFO_DEPTH(4)) dut_a (
    .CLOCK_50 (clk),
    .KEY      (key),
    .UART_RXD (rxd_a),
    .rx_data  (data_a),
    .rx_valid (valid_a),
    .rx_ready (ready_a),
    .frame_err(fe_a),
    .overrun  (ov_a),
    .busy     (busy_a)
  );

  uart_rx #(.CLKS_PER_BIT(SLOW), .FIFO_DEPTH(4)) dut_b (
    .CLOCK_50 (clk),
    .KEY      (key),
    .UART_RXD (rxd_b),
    .rx_data  (data_b),
    .rx_valid (valid_b),
    .rx_ready (ready_b),
    .frame_err(fe_b),
    .overrun  (ov_b),
    .busy     (busy_b)
  );

  always @(posedge clk) begin
    if (valid_a && ready_a) got_a.push_back(data_a);
    if (fe_a) fe_cnt++;
    if (ov_a) ov_cnt++;
    if (valid_b && ready_b) got_b.push_back(data_b);
    if (fe_b || ov_b) bad_b++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic put(input bit sel, input logic v, input int n);
    if (sel) rxd_b = v;
    else rxd_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input bit sel, input logic [7:0] b,
                      input logic stop);
    int cpb;
    cpb = sel ? SLOW : FAST;
    put(sel, 1'b0, cpb);
    for (int i = 0; i < 8; i++) put(sel, b[i], cpb);
    put(sel, stop, cpb);
  endtask

  task automatic drain(input int n);
    ready_a = 1'b1;
    repeat (n) @(negedge clk);
    ready_a = 1'b0;
  endtask

  initial begin
    int fe0;
    int ov0;
    logic [7:0] v;
    logic [7:0] burst [4];
    burst = '{8'h0F, 8'hFF, 8'h00, 8'h2D};

    repeat (3) @(negedge clk);
    chk("rst_valid", valid_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_fe", fe_a, 0);
    chk("rst_ov", ov_a, 0);
    key = 1'b0;
    repeat (4) @(negedge clk);

    // single 0x9A, ready high, with start-detect latency check
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    got_a.delete();
    ready_a = 1'b1;
    v = 8'h9A;
    rxd_a = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_t2", busy_a, 0);
    @(negedge clk);
    chk("busy_t3", busy_a, 1);
    repeat (FAST - 3) @(negedge clk);
    for (int i = 0; i < 8; i++) put(0, v[i], FAST);
    put(0, 1'b1, FAST);
    repeat (2 * FAST) @(negedge clk);
    chk("9a_count", got_a.size(), 1);
    chk("9a_data", got_a[0], 8'h9A);
    chk("9a_fe", fe_cnt - fe0, 0);
    chk("9a_ov", ov_cnt - ov0, 0);
    chk("9a_busy", busy_a, 0);
    chk("9a_valid", valid_a, 0);

    // four back-to-back frames held in the FIFO
    ready_a = 1'b0;
    got_a.delete();
    for (int i = 0; i < 4; i++) send(0, burst[i], 1'b1);
    repeat (2 * FAST) @(negedge clk);
    chk("b2b_valid", valid_a, 1);
    chk("b2b_head", data_a, 8'h0F);
    chk("b2b_ov", ov_cnt - ov0, 0);
    drain(8);
    chk("b2b_count", got_a.size(), 4);
    for (int i = 0; i < 4; i++) chk("b2b_data", got_a[i], burst[i]);
    chk("b2b_empty", valid_a, 0);

    // five frames into a four-deep FIFO
    got_a.delete();
    ov0 = ov_cnt;
    send(0, 8'h11, 1'b1);
    send(0, 8'h22, 1'b1);
    send(0, 8'h33, 1'b1);
    send(0, 8'h44, 1'b1);
    send(0, 8'h55, 1'b1);
    repeat (2 * FAST) @(negedge clk);
    chk("ovr_pulses", ov_cnt - ov0, 1);
    drain(8);
    chk("ovr_count", got_a.size(), 4);
    chk("ovr_d0", got_a[0], 8'h11);
    chk("ovr_d3", got_a[3], 8'h44);

    // bad stop bit then line held low
    got_a.delete();
    fe0 = fe_cnt;
    ready_a = 1'b1;
    send(0, 8'h55, 1'b0);
    put(0, 1'b0, 3 * FAST);
    chk("brk_busy", busy_a, 1);
    chk("brk_fe", fe_cnt - fe0, 1);
    put(0, 1'b1, 4);
    chk("brk_idle", busy_a, 0);
    repeat (2 * FAST) @(negedge clk);
    chk("brk_fe_once", fe_cnt - fe0, 1);
    chk("brk_nopush", got_a.size(), 0);

    // short glitch on idle line
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    put(0, 1'b0, HALF - 2);
    put(0, 1'b1, 2 * FAST);
    chk("gl_busy", busy_a, 0);
    chk("gl_nopush", got_a.size(), 0);
    chk("gl_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    // reset mid-frame with a byte already queued
    ready_a = 1'b0;
    send(0, 8'h77, 1'b1);
    repeat (2 * FAST) @(negedge clk);
    chk("mr_pre", valid_a, 1);
    v = 8'hA5;
    put(0, 1'b0, FAST);
    for (int i = 0; i < 3; i++) put(0, v[i], FAST);
    put(0, v[3], HALF);
    chk("mr_busy_pre", busy_a, 1);
    key = 1'b1;
    rxd_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("mr_valid", valid_a, 0);
    chk("mr_data", data_a, 0);
    chk("mr_busy", busy_a, 0);
    chk("mr_fe", fe_a, 0);
    chk("mr_ov", ov_a, 0);
    key = 1'b0;
    repeat (2) @(negedge clk);
    ready_a = 1'b1;
    send(0, 8'h3C, 1'b1);
    repeat (2 * FAST) @(negedge clk);
    chk("mr_count", got_a.size(), 1);
    chk("mr_byte", got_a[0], 8'h3C);

    // one frame at the full-rate divisor
    ready_b = 1'b1;
    send(1, 8'hC3, 1'b1);
    repeat (SLOW) @(negedge clk);
    chk("slow_count", got_b.size(), 1);
    chk("slow_byte", got_b[0], 8'hC3);
    chk("slow_flags", bad_b, 0);
    chk("slow_busy", busy_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive front end for the UART path: takes the raw asynchronous `UART_RXD` pin, recovers 8N1 frames at a fixed baud derived from `CLOCK_50`, and delivers bytes to downstream logic through a valid/ready interface backed by a small FIFO. It sits between the board pin and the command/echo logic inside the UART top. It also reports framing errors and overruns as single-cycle pulses.

## Interface

- `CLKS_PER_BIT`, 5208, clock cycles per bit (50 MHz / 9600 baud); must be ≥ 4.
- `FIFO_DEPTH`, 4, receive FIFO entries; power of two, ≥ 2.
- `CLOCK_50`  in  1  system clock, all logic on rising edge.
- `KEY`  in  1  reset: synchronous, active-high.
- `UART_RXD`  in  1  asynchronous serial line, idle high.
- `rx_data`  out  8  byte at FIFO head; valid only while `rx_valid`=1.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer accepts head when `rx_valid & rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: good byte dropped because FIFO full.
- `busy`  out  1  receiver FSM not in IDLE.

## Operation

- `UART_RXD` passes through a 2-flop synchronizer (flops reset to 1); FSM sees only `rxd_s`.
- `HALF` = `CLKS_PER_BIT/2` (integer division). Bit counter 3 bits, baud counter `$clog2(CLKS_PER_BIT)` bits.
- IDLE: `rxd_s`=0 → START, baud counter cleared.
- START: at count `HALF-1`, sample `rxd_s`. 0 → DATA, counter cleared, bit index 0. 1 → IDLE (glitch rejected, no flag).
- DATA: at count `CLKS_PER_BIT-1`, sample into shift register LSB first; after bit 7 → STOP.
- STOP: at count `CLKS_PER_BIT-1`, sample. 1 → push byte, IDLE. 0 → `frame_err` pulse, byte discarded, → BREAK.
- BREAK: wait until `rxd_s`=1, then IDLE (a held-low line produces exactly one `frame_err`).
- Push when FIFO full: byte dropped, `overrun` pulse, FIFO contents unchanged.
- FIFO: first-word fall-through; `rx_data` = head entry. Simultaneous push and pop on a full FIFO: pop and push both succeed, no overrun. On empty FIFO, push then visible next cycle (no same-cycle bypass).
- Reset mid-frame: FSM → IDLE, FIFO emptied, shift register and counters cleared; partially received frame lost with no flag.

## Timing

- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0; synchronizer flops 1.
- Pin falling edge at cycle t → `rxd_s` low at t+2 → START entered t+3, `busy`=1 from t+3.
- Data bit i sampled at t+3+HALF+(i+1)·CLKS_PER_BIT; stop at t+3+HALF+9·CLKS_PER_BIT (=s).
- Push at s+1; `rx_valid`=1 and `rx_data` correct from s+1 registered edge, i.e. observed at s+2. `frame_err`/`overrun` high exactly one cycle at s+1. `busy`=0 from s+1.
- Back-to-back frames: next start bit is detected from IDLE the cycle after STOP completes; no inter-frame gap required beyond one stop bit.
- Pop: head advances the cycle after `rx_valid & rx_ready`; `rx_valid` drops the same edge when last entry popped.

## Structure

- Shared package `uart_pkg`: FSM state enum (IDLE, START, DATA, STOP, BREAK), default `CLKS_PER_BIT` constant 5208, `DATA_BITS`=8.
- Sub-module `uart_rx_fifo` (synchronous FWFT FIFO, params `WIDTH`, `DEPTH`, ports push/din/full/pop/dout/empty); `uart_rx` instantiates it and the FSM inline.
- Test with `CLKS_PER_BIT`=16 for speed, plus one run at 5208.

## Test plan

- Single frame 0x9A (start, bits 0,1,0,1,1,0,0,1, stop) with `rx_ready`=1 → one `rx_valid` cycle, `rx_data`=0x9A, no flags.
- Back-to-back 0x0F, 0xFF, 0x00, 0x2D with `rx_ready`=0 → all four held; then pop → 0x0F, 0xFF, 0x00, 0x2D in order.
- Five frames, `rx_ready`=0, `FIFO_DEPTH`=4 → 5th frame gives one `overrun` pulse; FIFO reads first four bytes only.
- Frame 0x55 with stop bit low, line then held low 3 bit times → exactly one `frame_err`, no push, `busy` until line high.
- Low glitch of `HALF-2` cycles on idle line → no push, no flags, back to IDLE.
- `KEY` asserted mid-DATA of 0xA5, then released and 0x3C sent → only 0x3C delivered, all outputs at reset values during reset.
